if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/core_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 46 ++++
 rtl/if_stage.sv | 66 ++++++
 tb/tb_if_stage.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants and the fetch-entry type
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry circular buffer of fetched {pc, instr} entries
module fetch_fifo
    import core_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  fetch_entry_t  wdata,
    output fetch_entry_t  rdata,
    output logic [CW-1:0] count
);

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    // DEPTH need not be a power of two, so pointers wrap explicitly
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= wdata;
    end

    assign rdata = mem[head];

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC sequencing, redirect and fetch buffer
module if_stage
    import core_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-3:0] imem_addr_o,
    input  logic [WIDTH-1:0] imem_data_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             id_valid_o,
    input  logic             id_ready_i,
    output logic [WIDTH-1:0] id_pc_o,
    output logic [WIDTH-1:0] id_instr_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] pc_q;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;
    fetch_entry_t     wdata;
    fetch_entry_t     rdata;

    assign imem_addr_o = pc_q[WIDTH-1:2];
    assign id_valid_o  = (count != '0);
    assign pop         = id_valid_o & id_ready_i;
    // A full buffer still accepts a fetch when decode drains an entry this cycle
    assign push        = ~redirect_i & ((count < CW'(DEPTH)) | pop);

    assign wdata.pc    = pc_q;
    assign wdata.instr = imem_data_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= {RESET_PC[WIDTH-1:2], 2'b00};
        end else if (redirect_i) begin
            pc_q <= {redirect_pc_i[WIDTH-1:2], 2'b00};
        end else if (push) begin
            pc_q <= pc_q + WIDTH'(4);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_i),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .count (count)
    );

    // Idle outputs present a NOP at PC 0 so downstream never sees stale data
    assign id_pc_o    = id_valid_o ? rdata.pc    : '0;
    assign id_instr_o = id_valid_o ? rdata.instr : NOP_INSTR;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage
module tb_if_stage;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_instr_o;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] exp_q [$];
    logic [31:0] mpc;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    assign imem_data_i = imem_word({imem_addr_o, 2'b00});

    if_stage #(
        .WIDTH    (32),
        .RESET_PC (RPC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr_o   (imem_addr_o),
        .imem_data_i   (imem_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_pc_o       (id_pc_o),
        .id_instr_o    (id_instr_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare DUT outputs with the scoreboard head, then advance the model by the inputs applied
    task automatic cyc(input logic rn, input logic rdy, input logic rd, input logic [31:0] tgt);
        int  sz;
        bit  pop;
        @(negedge clk);
        rst_n = rn; id_ready_i = rdy; redirect_i = rd; redirect_pc_i = tgt;
        #1;
        sz = exp_q.size();
        check("valid", {31'b0, id_valid_o}, {31'b0, sz > 0});
        if (sz > 0) begin
            check("pc", id_pc_o, exp_q[0]);
            check("instr", id_instr_o, imem_word(exp_q[0]));
        end else begin
            check("idle_pc", id_pc_o, 32'h0);
            check("idle_instr", id_instr_o, NOP);
        end
        check("imem_addr", {2'b00, imem_addr_o}, {2'b00, mpc[31:2]});
        if (!rn) begin
            exp_q.delete();
            mpc = RPC;
        end else if (rd) begin
            exp_q.delete();
            mpc = {tgt[31:2], 2'b00};
        end else begin
            pop = (sz > 0) && rdy;
            if (pop) void'(exp_q.pop_front());
            if (sz < DEPTH || pop) begin
                exp_q.push_back(mpc);
                mpc = mpc + 32'd4;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; id_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        repeat (2) @(posedge clk);
        mpc = RPC;

        // reset state, then streaming 0x0, 0x4, 0x8...
        cyc(0, 1, 0, 0);
        repeat (6) cyc(1, 1, 0, 0);

        // stall from fresh reset: buffer fills, PC stops at 0x8
        cyc(0, 0, 0, 0);
        repeat (5) cyc(1, 0, 0, 0);
        check("stall_addr", {2'b00, imem_addr_o}, 32'h2);
        check("stall_pc", id_pc_o, 32'h0);

        // redirect to unaligned target while full
        cyc(1, 0, 1, 32'h0000_0103);
        cyc(1, 1, 0, 0);
        check("redir_idle", {31'b0, id_valid_o}, 32'h0);
        cyc(1, 1, 0, 0);
        check("redir_pc", id_pc_o, 32'h0000_0100);
        repeat (3) cyc(1, 1, 0, 0);

        // redirect coinciding with a pop
        cyc(1, 1, 1, 32'h0000_0200);
        cyc(1, 1, 0, 0);
        repeat (3) cyc(1, 1, 0, 0);

        // PC wrap at the top of the address space
        cyc(1, 1, 1, 32'hFFFF_FFFC);
        repeat (5) cyc(1, 1, 0, 0);

        // back-to-back redirects: only the last target is fetched
        cyc(1, 1, 1, 32'h0000_0300);
        cyc(1, 1, 1, 32'h0000_0400);
        repeat (4) cyc(1, 1, 0, 0);

        // reset while holding two entries
        repeat (4) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (3) cyc(1, 1, 0, 0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 63) != 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 15) == 0),
                $urandom());
        end
        cyc(1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
